// File: rtl/rs_bank.sv
// Reservation-station entry bank: in-order dispatch allocation, CDB wakeup, issue clears, flush.
// Optional RS_DISPATCH_WAKEUP_EN: a dispatching source that matches a same-cycle CDB tag is written ready.
module rs_bank #(
    parameter int N     = 8,
    parameter int W     = 2,
    parameter int C     = 2,
    parameter int K     = 2,
    parameter int TAG_W = 6,
    parameter int P     = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [W-1:0]              disp_valid,
    input  logic [W*TAG_W-1:0]        disp_src1_tag,
    input  logic [W*TAG_W-1:0]        disp_src2_tag,
    input  logic [W*TAG_W-1:0]        disp_dest_tag,
    input  logic [W-1:0]              disp_src1_rdy,
    input  logic [W-1:0]              disp_src2_rdy,
    input  logic [W*P-1:0]            disp_payload,
    input  logic [C-1:0]              cdb_valid,
    input  logic [C*TAG_W-1:0]        cdb_tag,
    input  logic [K-1:0]              clear_valid,
    input  logic [K*$clog2(N)-1:0]    clear_idx,
    output logic [N-1:0]              ent_valid,
    output logic [N-1:0]              ent_ready,
    output logic [N*TAG_W-1:0]        ent_src1_tag,
    output logic [N*TAG_W-1:0]        ent_src2_tag,
    output logic [N*TAG_W-1:0]        ent_dest_tag,
    output logic [N*P-1:0]            ent_payload,
    output logic [$clog2(N+1)-1:0]    free_count,
    output logic                      overflow_err
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]       valid_q, valid_d, s1_q, s1_d, s2_q, s2_d, ready_q, ready_d;
    logic [N*TAG_W-1:0] src1_tag_q, src1_tag_d, src2_tag_q, src2_tag_d, dest_tag_q, dest_tag_d;
    logic [N*P-1:0]     payload_q, payload_d;
    logic [CW-1:0]      free_q, free_d;
    logic               ovf_q, ovf_d;
    logic [N-1:0]       taken_s, clr_mask_s;
    logic               found_s;
    logic [CW-1:0]      pop_s;
    logic [TAG_W-1:0]   tag1_s, tag2_s;

    function automatic logic cdb_hit(input logic [TAG_W-1:0] tag,
                                     input logic [C-1:0] v,
                                     input logic [C*TAG_W-1:0] t);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < C; c++) begin
            hit = hit | (v[c] & (t[c*TAG_W +: TAG_W] == tag));
        end
        return hit;
    endfunction

    // Next-state: wakeup, then clears, then dispatch into entries free at the start of the cycle.
    always_comb begin
        valid_d    = valid_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        src1_tag_d = src1_tag_q;
        src2_tag_d = src2_tag_q;
        dest_tag_d = dest_tag_q;
        payload_d  = payload_q;
        taken_s    = {N{1'b0}};
        clr_mask_s = {N{1'b0}};
        found_s    = 1'b0;
        ovf_d      = 1'b0;
        pop_s      = {CW{1'b0}};
        tag1_s     = {TAG_W{1'b0}};
        tag2_s     = {TAG_W{1'b0}};

        for (int e = 0; e < N; e++) begin
            s1_d[e] = s1_q[e] | (valid_q[e] & cdb_hit(src1_tag_q[e*TAG_W +: TAG_W], cdb_valid, cdb_tag));
            s2_d[e] = s2_q[e] | (valid_q[e] & cdb_hit(src2_tag_q[e*TAG_W +: TAG_W], cdb_valid, cdb_tag));
        end

        // A clear beats a same-cycle wakeup; clearing an invalid entry changes nothing visible.
        for (int k = 0; k < K; k++) begin
            clr_mask_s = clr_mask_s |
                ({{(N-1){1'b0}}, clear_valid[k]} << clear_idx[k*IW +: IW]);
        end
        valid_d = valid_d & ~clr_mask_s;
        s1_d    = s1_d & ~clr_mask_s;
        s2_d    = s2_d & ~clr_mask_s;

        for (int w = 0; w < W; w++) begin
            found_s = 1'b0;
            if (disp_valid[w]) begin
                tag1_s = disp_src1_tag[w*TAG_W +: TAG_W];
                tag2_s = disp_src2_tag[w*TAG_W +: TAG_W];
                for (int e = 0; e < N; e++) begin
                    if (!found_s && !valid_q[e] && !taken_s[e]) begin
                        found_s    = 1'b1;
                        taken_s[e] = 1'b1;
                        valid_d[e] = 1'b1;
`ifdef RS_DISPATCH_WAKEUP_EN
                        s1_d[e] = disp_src1_rdy[w] | (tag1_s == {TAG_W{1'b0}}) |
                                  cdb_hit(tag1_s, cdb_valid, cdb_tag);
                        s2_d[e] = disp_src2_rdy[w] | (tag2_s == {TAG_W{1'b0}}) |
                                  cdb_hit(tag2_s, cdb_valid, cdb_tag);
`else
                        s1_d[e] = disp_src1_rdy[w] | (tag1_s == {TAG_W{1'b0}});
                        s2_d[e] = disp_src2_rdy[w] | (tag2_s == {TAG_W{1'b0}});
`endif
                        src1_tag_d[e*TAG_W +: TAG_W] = tag1_s;
                        src2_tag_d[e*TAG_W +: TAG_W] = tag2_s;
                        dest_tag_d[e*TAG_W +: TAG_W] = disp_dest_tag[w*TAG_W +: TAG_W];
                        payload_d[e*P +: P]          = disp_payload[w*P +: P];
                    end else begin
                        taken_s[e] = taken_s[e];
                    end
                end
                ovf_d = ovf_d | ~found_s;
            end else begin
                ovf_d = ovf_d;
            end
        end

        if (flush) begin
            valid_d = {N{1'b0}};
            s1_d    = {N{1'b0}};
            s2_d    = {N{1'b0}};
            ovf_d   = 1'b0;
        end else begin
            valid_d = valid_d;
        end

        ready_d = valid_d & s1_d & s2_d;
        for (int e = 0; e < N; e++) begin
            pop_s = pop_s + {{(CW-1){1'b0}}, valid_d[e]};
        end
        free_d = CW'(N) - pop_s;
    end

    // Control state: valid/ready bits, free count and overflow pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= {N{1'b0}};
            s1_q    <= {N{1'b0}};
            s2_q    <= {N{1'b0}};
            ready_q <= {N{1'b0}};
            free_q  <= CW'(N);
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            ready_q <= ready_d;
            free_q  <= free_d;
            ovf_q   <= ovf_d;
        end
    end

    // Data fields are meaningless while an entry is invalid, so they carry no reset.
    always_ff @(posedge clock) begin
        src1_tag_q <= src1_tag_d;
        src2_tag_q <= src2_tag_d;
        dest_tag_q <= dest_tag_d;
        payload_q  <= payload_d;
    end

    assign ent_valid    = valid_q;
    assign ent_ready    = ready_q;
    assign ent_src1_tag = src1_tag_q;
    assign ent_src2_tag = src2_tag_q;
    assign ent_dest_tag = dest_tag_q;
    assign ent_payload  = payload_q;
    assign free_count   = free_q;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_rs_bank.sv
// Self-checking bench for rs_bank (N=8, W=2, C=2, K=2): vector table plus hand-written corner sequences.
module tb_rs_bank;

    logic          clock = 1'b0;
    logic          reset, flush;
    logic [1:0]    disp_valid, disp_src1_rdy, disp_src2_rdy;
    logic [11:0]   disp_src1_tag, disp_src2_tag, disp_dest_tag;
    logic [127:0]  disp_payload;
    logic [1:0]    cdb_valid, clear_valid;
    logic [11:0]   cdb_tag;
    logic [5:0]    clear_idx;
    logic [7:0]    ent_valid, ent_ready;
    logic [47:0]   ent_src1_tag, ent_src2_tag, ent_dest_tag;
    logic [511:0]  ent_payload;
    logic [3:0]    free_count;
    logic          overflow_err;

    rs_bank dut (
        .clock(clock), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_dest_tag(disp_dest_tag), .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_payload(disp_payload), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .clear_valid(clear_valid), .clear_idx(clear_idx),
        .ent_valid(ent_valid), .ent_ready(ent_ready), .ent_src1_tag(ent_src1_tag),
        .ent_src2_tag(ent_src2_tag), .ent_dest_tag(ent_dest_tag), .ent_payload(ent_payload),
        .free_count(free_count), .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

`ifdef RS_DISPATCH_WAKEUP_EN
    localparam logic [7:0] ER0 = 8'h01;
`else
    localparam logic [7:0] ER0 = 8'h00;
`endif

    // rdy = {lane1 src2, lane1 src1, lane0 src2, lane0 src1}; ct == 63 skips the tag check
    typedef struct {
        logic       rs, fl;
        logic [1:0] dv;
        logic [5:0] a1, a2, b1, b2;
        logic [3:0] rdy;
        logic [1:0] cv;
        logic [5:0] c0, c1;
        logic [1:0] kv;
        logic [2:0] k0, k1;
        logic [7:0] ev, er;
        logic [3:0] ef;
        logic       eo;
        logic [2:0] ce;
        logic [5:0] ct;
    } vec_t;

    vec_t vecs[18];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   vec_no   = 0;

    function automatic vec_t mk(int rs, int fl, int dv, int a1, int a2, int b1, int b2, int rdy,
                                int cv, int c0, int c1, int kv, int k0, int k1,
                                int ev, int er, int ef, int eo, int ce, int ct);
        vec_t v;
        v.rs = rs[0]; v.fl = fl[0]; v.dv = dv[1:0];
        v.a1 = a1[5:0]; v.a2 = a2[5:0]; v.b1 = b1[5:0]; v.b2 = b2[5:0]; v.rdy = rdy[3:0];
        v.cv = cv[1:0]; v.c0 = c0[5:0]; v.c1 = c1[5:0];
        v.kv = kv[1:0]; v.k0 = k0[2:0]; v.k1 = k1[2:0];
        v.ev = ev[7:0]; v.er = er[7:0]; v.ef = ef[3:0]; v.eo = eo[0];
        v.ce = ce[2:0]; v.ct = ct[5:0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %0h, expected %0h", nm, vec_no, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        reset         = v.rs;
        flush         = v.fl;
        disp_valid    = v.dv;
        disp_src1_tag = {v.b1, v.a1};
        disp_src2_tag = {v.b2, v.a2};
        disp_dest_tag = {6'd34, 6'd33};
        disp_src1_rdy = {v.rdy[2], v.rdy[0]};
        disp_src2_rdy = {v.rdy[3], v.rdy[1]};
        disp_payload  = {64'(v.b1), 64'(v.a1)};
        cdb_valid     = v.cv;
        cdb_tag       = {v.c1, v.c0};
        clear_valid   = v.kv;
        clear_idx     = {v.k1, v.k0};
        exp_q.push_back(v);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        chk("ent_valid", ent_valid, e.ev);
        chk("ent_ready", ent_ready, e.er);
        chk("free_count", {4'd0, free_count}, {4'd0, e.ef});
        chk("overflow_err", {7'd0, overflow_err}, {7'd0, e.eo});
        if (e.ct != 6'd63) begin
            chk("src1_tag", {2'd0, ent_src1_tag[int'(e.ce)*6 +: 6]}, {2'd0, e.ct});
        end
        vec_no++;
    endtask

    initial begin
        //              rs fl dv  a1 a2 b1 b2 rdy cv c0 c1 kv k0 k1   ev    er   ef eo ce ct
        vecs[0]  = mk(1, 0, 3,  5, 6, 7, 8, 0,  3, 5, 6, 0, 0, 0, 'h00, 'h00, 8, 0, 0, 63); // reset mid-dispatch
        vecs[1]  = mk(0, 0, 3,  5, 6, 7, 8, 0,  0, 0, 0, 0, 0, 0, 'h03, 'h00, 6, 0, 0,  5);
        vecs[2]  = mk(0, 0, 0,  0, 0, 0, 0, 0,  1, 5, 0, 0, 0, 0, 'h03, 'h00, 6, 0, 1,  7);
        vecs[3]  = mk(0, 0, 0,  0, 0, 0, 0, 0,  2, 0, 6, 0, 0, 0, 'h03, 'h01, 6, 0, 0,  5);
        vecs[4]  = mk(0, 0, 0,  0, 0, 0, 0, 0,  3, 7, 8, 0, 0, 0, 'h03, 'h03, 6, 0, 1,  7);
        vecs[5]  = mk(0, 0, 3, 10, 0,11, 0, 4,  0, 0, 0, 0, 0, 0, 'h0F, 'h0B, 4, 0, 3, 11);
        vecs[6]  = mk(0, 0, 3, 12, 0,13, 0, 1,  0, 0, 0, 0, 0, 0, 'h3F, 'h1B, 2, 0, 5, 13);
        vecs[7]  = mk(0, 0, 2,  0, 0,14, 0, 0,  0, 0, 0, 0, 0, 0, 'h7F, 'h1B, 1, 0, 6, 14);
        vecs[8]  = mk(0, 0, 3, 15, 0,16, 0, 5,  0, 0, 0, 0, 0, 0, 'hFF, 'h9B, 0, 1, 7, 15); // overflow
        vecs[9]  = mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 'hFF, 'h9B, 0, 0, 7, 15);
        vecs[10] = mk(0, 0, 1, 20, 0, 0, 0, 1,  0, 0, 0, 1, 3, 0, 'hF7, 'h93, 1, 1, 3, 11); // no same-cycle reuse
        vecs[11] = mk(0, 0, 1, 20, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 'hFF, 'h9B, 0, 0, 3, 20);
        vecs[12] = mk(0, 0, 0,  0, 0, 0, 0, 0,  1,10, 0, 3, 2, 2, 'hFB, 'h9B, 1, 0, 2, 10); // clear beats wakeup, dup idx
        vecs[13] = mk(0, 0, 1, 10, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 'hFF, 'h9B, 0, 0, 2, 10);
        vecs[14] = mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 3, 5, 6, 'h9F, 'h9B, 2, 0, 2, 10);
        vecs[15] = mk(0, 0, 3, 21, 0,22, 0, 4,  0, 0, 0, 1, 5, 0, 'hFF, 'hDB, 0, 0, 5, 21); // clear of invalid entry
        vecs[16] = mk(0, 0, 0,  0, 0, 0, 0, 0,  1,21, 0, 1, 0, 0, 'hFE, 'hFA, 1, 0, 5, 21);
        vecs[17] = mk(0, 1, 3, 23, 0,24, 0, 5,  1,22, 0, 1, 1, 0, 'h00, 'h00, 8, 0, 0, 63); // flush wins

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i]);
        end

        // Same-cycle dispatch/CDB match, then flush of a 4-entry bank.
        apply(mk(0, 0, 1,  9, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 'h01, ER0,          7, 0, 0,  9));
        apply(mk(0, 0, 3, 30, 0,31, 0, 1, 0, 0, 0, 0, 0, 0, 'h07, ER0 | 8'h02,  5, 0, 2, 31));
        apply(mk(0, 0, 2,  0, 0,32, 0, 4, 0, 0, 0, 0, 0, 0, 'h0F, ER0 | 8'h0A,  4, 0, 3, 32));
        apply(mk(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 'h00,         8, 0, 0, 63));

        // Reset arriving during dispatch and wakeup discards everything.
        apply(mk(0, 0, 3, 40, 0,41, 0, 0, 0, 0, 0, 0, 0, 0, 'h03, 'h00,         6, 0, 1, 41));
        apply(mk(1, 0, 3, 42, 0,43, 0, 0, 3,40,41, 0, 0, 0, 'h00, 'h00,         8, 0, 0, 63));
        apply(mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h00, 'h00,         8, 0, 0, 63));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
